// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port synchronous memory between two requesters:
//   port 0 (cpu) and port 1 (debug/monitor loader). Each port uses a req/ack
//   handshake. Only one access is in flight at a time. The memory command
//   (mem_we/mem_addr/mem_data) is registered.
//
//   Access sequence:  IDLE -> ACCESS -> IDLE            (write, ack in ACCESS)
//                     IDLE -> ACCESS -> RDATA -> IDLE   (read,  ack in RDATA)
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req0/req1         access request, held until ack
//   we0/we1           1 = write, 0 = read (stable while req)
//   addr0/addr1       access address (stable while req)
//   wdata0/wdata1     write data (stable while req)
//   ack0/ack1         one-cycle completion pulse
//   rdata0/rdata1     read result, valid in the ack cycle, held until the next
//                     read ack on that port
//   mem_we/addr/data  registered memory command
//   mem_out           memory read data, valid one clock after the address
//   busy              high whenever the FSM is not IDLE
//   owner             port owning the current/last access
//
// Configuration macro
//   MEM_ARB_FIXED_PRIO_EN  defined: port 0 always wins simultaneous requests.
//                          undefined (default): round-robin arbitration.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out,
  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RDATA  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_owner;
  logic                  r_ack0;
  logic                  r_ack1;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic                  r_last;     // last-served port
`endif

  logic                  w_any_req;
  logic                  w_grant;    // winning port index
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

  // Winner selection. A lone requester always wins; with both requesting,
  // round-robin grants the port that was not served last.
  always_comb begin
    w_any_req = req0 | req1;
`ifdef MEM_ARB_FIXED_PRIO_EN
    w_grant = ~req0;
`else
    if (req0 && req1) begin
      w_grant = ~r_last;
    end else begin
      w_grant = ~req0;
    end
`endif
  end

  assign w_we    = w_grant ? we1    : we0;
  assign w_addr  = w_grant ? addr1  : addr0;
  assign w_wdata = w_grant ? wdata1 : wdata0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      r_last     <= 1'b1;    // port 0 wins the first contest
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack0   <= 1'b0;
          r_ack1   <= 1'b0;
          r_mem_we <= 1'b0;
          if (w_any_req) begin
            r_mem_we   <= w_we;
            r_mem_addr <= w_addr;
            r_mem_data <= w_wdata;
            r_owner    <= w_grant;
`ifndef MEM_ARB_FIXED_PRIO_EN
            r_last     <= w_grant;
`endif
            r_state    <= S_ACCESS;
            // A write completes in ACCESS, so its ack is registered now to
            // line up with the mem_we cycle.
            if (w_we) begin
              r_ack0 <= ~w_grant;
              r_ack1 <= w_grant;
            end
          end
        end

        S_ACCESS: begin
          r_mem_we <= 1'b0;
          if (r_mem_we) begin
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            // Read: memory samples the address on this edge; data and ack
            // both appear in RDATA.
            r_ack0  <= ~r_owner;
            r_ack1  <= r_owner;
            r_state <= S_RDATA;
          end
        end

        S_RDATA: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_state <= S_IDLE;
          if (r_owner) begin
            r_rdata1 <= mem_out;
          end else begin
            r_rdata0 <= mem_out;
          end
        end

        default: begin
          r_ack0   <= 1'b0;
          r_ack1   <= 1'b0;
          r_mem_we <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // mem_out only becomes valid during RDATA, so the owner's rdata passes it
  // straight through in the ack cycle and holds the captured copy afterwards.
  assign rdata0 = (r_state == S_RDATA && !r_owner) ? mem_out : r_rdata0;
  assign rdata1 = (r_state == S_RDATA &&  r_owner) ? mem_out : r_rdata1;

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign busy     = (r_state != S_IDLE);
  assign owner    = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter with a registered-read memory attached.
//   A transaction-level model (grant cycle + fixed latency, shadow memory)
//   predicts every output on every cycle; directed scenarios add literal
//   expectations, then randomized requesters exercise both ports.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a   [2];
  logic        we_a    [2];
  logic [5:0]  addr_a  [2];
  logic [15:0] wdata_a [2];

  logic        ack0, ack1, mem_we, busy, owner;
  logic [15:0] rdata0, rdata1, mem_data, mem_out;
  logic [5:0]  mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req_a[0]), .req1(req_a[1]),
    .we0(we_a[0]), .we1(we_a[1]),
    .addr0(addr_a[0]), .addr1(addr_a[1]),
    .wdata0(wdata_a[0]), .wdata1(wdata_a[1]),
    .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_out(mem_out), .busy(busy), .owner(owner)
  );

  // Memory attached to the arbiter: synchronous write, registered read.
  logic [15:0] mem_arr [64];
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr] <= mem_data;
    mem_out <= mem_arr[mem_addr];
  end

  function automatic logic [15:0] init_val(input int i);
    init_val = 16'hA000 + 16'(i) * 16'h0101;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: each access is a grant cycle g plus fixed latency.
  // Access occupies cycles g+1..done; done = g+1 (write) or g+2 (read).
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  int          prev_c;
  int          win;
  bit          m_act = 0;
  int          m_port;
  bit          m_we;
  logic [5:0]  m_addr;
  logic [15:0] m_data;
  int          m_grant, m_done;
  bit          m_last = 1;
  logic [15:0] shadow [64];
  logic [15:0] e_rdata [2];
  int          e_owner = 0;
  logic [5:0]  e_addr = '0;
  logic [15:0] e_data = '0;

  always @(posedge clk) begin
    cyc    = cyc + 1;
    prev_c = cyc - 1;
    if (rst) begin
      m_act      = 0;
      m_last     = 1;
      e_owner    = 0;
      e_addr     = '0;
      e_data     = '0;
      e_rdata[0] = '0;
      e_rdata[1] = '0;
    end else begin
      if (m_act && m_we && prev_c == m_grant + 1) shadow[m_addr] = m_data;
      if ((!m_act || prev_c > m_done) && (req_a[0] || req_a[1])) begin
        if (req_a[0] && req_a[1]) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          win = 0;
`else
          win = (m_last == 1'b0) ? 1 : 0;
`endif
        end else begin
          win = req_a[0] ? 0 : 1;
        end
        m_last  = win[0];
        m_act   = 1;
        m_port  = win;
        m_we    = we_a[win];
        m_addr  = addr_a[win];
        m_data  = wdata_a[win];
        m_grant = prev_c;
        m_done  = prev_c + (m_we ? 1 : 2);
        e_owner = win;
        e_addr  = addr_a[win];
        e_data  = wdata_a[win];
      end
      if (m_act && !m_we && cyc == m_done) e_rdata[m_port] = shadow[m_addr];
    end
  end

  // Per-cycle compare against the model.
  bit e_busy, e_ack0, e_ack1, e_we;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_ack0", ack0, 0);
      chk("rst_ack1", ack1, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data", mem_data, 0);
      chk("rst_owner", owner, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
    end else begin
      e_busy = m_act && cyc >= m_grant + 1 && cyc <= m_done;
      e_ack0 = m_act && cyc == m_done && m_port == 0;
      e_ack1 = m_act && cyc == m_done && m_port == 1;
      e_we   = m_act && m_we && cyc == m_grant + 1;
      chk("busy", busy, e_busy);
      chk("ack0", ack0, e_ack0);
      chk("ack1", ack1, e_ack1);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_data", mem_data, e_data);
      chk("owner", owner, e_owner);
      chk("rdata0", rdata0, e_rdata[0]);
      chk("rdata1", rdata1, e_rdata[1]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_a[0] = 1'b0; req_a[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One access from an idle arbiter; lat counts cycles from the request cycle.
  task automatic access(input int p, input bit w, input logic [5:0] a,
                        input logic [15:0] d, output logic [15:0] rd, output int lat);
    @(posedge clk); #1;
    req_a[p] = 1'b1; we_a[p] = w; addr_a[p] = a; wdata_a[p] = d;
    lat = -1;
    rd  = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((p == 0 && ack0) || (p == 1 && ack1)) begin
        lat = i;
        rd  = (p == 0) ? rdata0 : rdata1;
        break;
      end
    end
    @(posedge clk); #1;
    req_a[p] = 1'b0;
    if (lat < 0) chk("access_timeout", 1, 0);
  endtask

  logic [15:0] rd;
  int          lat;
  int          ack_n;
  int          ack_cyc  [4];
  int          ack_port [4];
  int          st [2];
  bit          seen [2];
  bit          drained;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = init_val(i);
      shadow[i]  = init_val(i);
    end
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req_a[p] = 1'b0; we_a[p] = 1'b0; addr_a[p] = '0; wdata_a[p] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_owner", owner, 0);

    // Write then read back on port 0.
    access(0, 1'b1, 6'd5, 16'hBEEF, rd, lat);
    chk("t2_write_latency", lat, 1);
    access(0, 1'b0, 6'd5, 16'h0000, rd, lat);
    chk("t2_read_latency", lat, 2);
    chk("t2_read_data", rd, 16'hBEEF);

    // Both ports reading continuously: alternating owners, 3-cycle spacing.
    do_reset();
    @(posedge clk); #1;
    req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0] = 6'd1;
    req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1] = 6'd2;
    ack_n = 0;
    for (int i = 0; i < 40 && ack_n < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        ack_cyc[ack_n]  = i;
        ack_port[ack_n] = ack1 ? 1 : 0;
        ack_n++;
      end
    end
    @(posedge clk); #1;
    req_a[0] = 1'b0; req_a[1] = 1'b0;
    chk("t3_ack_count", ack_n, 4);
    for (int i = 0; i < 4 && i < ack_n; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      chk("t3_ack_port", ack_port[i], 0);
`else
      chk("t3_ack_port", ack_port[i], i % 2);
`endif
      if (i > 0) chk("t3_ack_spacing", ack_cyc[i] - ack_cyc[i-1], 3);
    end

    // Port 1 read arrives while a port 0 write is in ACCESS.
    @(posedge clk); #1;
    req_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 6'd7; wdata_a[0] = 16'h5A5A;
    @(negedge clk);
    @(posedge clk); #1;
    req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1] = 6'd3;
    @(negedge clk);
    chk("t5_ack0", ack0, 1);
    chk("t5_ack1_idle", ack1, 0);
    @(posedge clk); #1;
    req_a[0] = 1'b0;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack1) begin lat = i; rd = rdata1; break; end
    end
    @(posedge clk); #1;
    req_a[1] = 1'b0;
    chk("t5_port1_latency", lat, 2);
    chk("t5_rdata1", rd, 16'hA303);

    // Requester drops req during ACCESS of a write.
    @(posedge clk); #1;
    req_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 6'd9; wdata_a[0] = 16'h1234;
    @(negedge clk);
    @(posedge clk); #1;
    req_a[0] = 1'b0;
    @(negedge clk);
    chk("t6_ack0", ack0, 1);
    chk("t6_mem_we", mem_we, 1);
    chk("t6_mem_addr", mem_addr, 9);
    chk("t6_mem_data", mem_data, 16'h1234);
    @(negedge clk);
    chk("t6_ack0_done", ack0, 0);
    chk("t6_busy_done", busy, 0);
    access(0, 1'b0, 6'd9, 16'h0000, rd, lat);
    chk("t6_readback", rd, 16'h1234);

    // Randomized requesters on both ports.
    st[0] = 0; st[1] = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      seen[0] = ack0; seen[1] = ack1;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        case (st[p])
          0: if ($urandom_range(0, 2) == 0) begin
               req_a[p]   = 1'b1;
               we_a[p]    = 1'($urandom_range(0, 1));
               addr_a[p]  = 6'($urandom_range(0, 7));
               wdata_a[p] = 16'($urandom);
               st[p]      = 1;
             end
          1: if (seen[p]) begin
               req_a[p] = 1'b0;
               st[p]    = 0;
             end else if (m_act && m_port == p && cyc >= m_grant + 1 && cyc <= m_done
                          && $urandom_range(0, 3) == 0) begin
               req_a[p] = 1'b0;
               st[p]    = 2;
             end
          default: if (seen[p]) st[p] = 0;
        endcase
      end
    end
    drained = 0;
    for (int t = 0; t < 100 && !drained; t++) begin
      @(negedge clk);
      seen[0] = ack0; seen[1] = ack1;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (st[p] != 0 && seen[p]) begin
          req_a[p] = 1'b0;
          st[p]    = 0;
        end
      end
      drained = (st[0] == 0 && st[1] == 0);
    end
    chk("drain_done", drained, 1);
    req_a[0] = 1'b0; req_a[1] = 1'b0;
    repeat (2) @(posedge clk);

    // Reset asserted in the middle of a read's RDATA cycle.
    @(posedge clk); #1;
    req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0] = 6'd5;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    req_a[0] = 1'b0;
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_ack0", ack0, 0);
    chk("t1_ack1", ack1, 0);
    chk("t1_rdata0", rdata0, 0);
    chk("t1_mem_addr", mem_addr, 0);
    chk("t1_owner", owner, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_idle_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
